// File: rtl/serial_add_sub_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : serial_add_sub_if
// Purpose  : Request/result bundle for the serial adder/subtractor.
//            The master side drives an operation request and receives the
//            result with its flags. The slave side is the arithmetic unit.
// Ports    : start, sub, a, b           request (master -> slave)
//            busy, done, s, cout, ovf,  status and result (slave -> master)
//            zero
// Revision : 1.0  initial release
// ============================================================================
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : serial_add_sub
// Purpose  : Multi-cycle two's-complement adder/subtractor. Handles DIGIT
//            bits per clock, least significant digit first, through a
//            DIGIT-bit ripple-carry slice. Latency is WIDTH/DIGIT + 1 cycles
//            from the start edge to the done pulse.
// Ports    : clk   clock, rising edge active
//            rst   synchronous active-high reset
//            bus   slave side of serial_add_sub_if
//                    start/sub/a/b    request, sampled only while not busy
//                    busy             operation in progress
//                    done             one-cycle pulse, result updated
//                    s/cout/ovf/zero  result and flags, held until next done
// Revision : 1.0  initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    serial_add_sub_if.slave  bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtraction
    logic [WIDTH-1:0] acc_q, acc_d;   // sum slices shifted in from the top
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // ------------------------------------------------------------------
    // Control decodes
    // ------------------------------------------------------------------
    logic w_load;
    logic w_last;

    // A request is accepted whenever the unit is not in RUN (busy is low
    // in both IDLE and DONE).
    assign w_load = bus.start && (state_q != ST_RUN);
    assign w_last = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // DIGIT-bit ripple slice on the low digit of the operand registers
    // ------------------------------------------------------------------
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_sum;

    assign w_c[0] = carry_q;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign w_sum[i]   = a_q[i] ^ b_q[i] ^ w_c[i];
            assign w_c[i+1]   = (a_q[i] & b_q[i]) | (w_c[i] & (a_q[i] ^ b_q[i]));
        end
    endgenerate

    // Shifts are built on a widened vector so they stay legal when DIGIT
    // equals WIDTH (single-slice configuration).
    logic [WIDTH+DIGIT-1:0] w_acc_cat;
    logic [WIDTH+DIGIT-1:0] w_a_cat;
    logic [WIDTH+DIGIT-1:0] w_b_cat;
    logic [WIDTH-1:0]       w_acc_shift;
    logic [WIDTH-1:0]       w_a_shift;
    logic [WIDTH-1:0]       w_b_shift;

    assign w_acc_cat   = {w_sum, acc_q};
    assign w_a_cat     = {{DIGIT{1'b0}}, a_q};
    assign w_b_cat     = {{DIGIT{1'b0}}, b_q};
    assign w_acc_shift = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_a_shift   = w_a_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_b_shift   = w_b_cat[WIDTH+DIGIT-1:DIGIT];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (w_last)    state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_done;

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (state_q)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        if (w_load) begin
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as
            // the initial carry.
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.sub}};
            carry_d = bus.sub;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_d     = w_a_shift;
            b_d     = w_b_shift;
            acc_d   = w_acc_shift;
            carry_d = w_c[DIGIT];
            cnt_d   = cnt_q + CNT_W'(1);
            if (w_last) begin
                // On the final slice w_c[DIGIT-1] is the carry into the
                // result MSB and w_c[DIGIT] is the carry out of it.
                s_d    = w_acc_shift;
                cout_d = w_c[DIGIT];
                ovf_d  = w_c[DIGIT-1] ^ w_c[DIGIT];
                zero_d = ~|w_acc_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_add_sub
// Purpose  : Directed self-checking bench for serial_add_sub, an 8-bit
//            bit-serial instance and a 16-bit 4-bit-digit instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_sub;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    serial_add_sub_if #(.WIDTH(8))  bus8 ();
    serial_add_sub_if #(.WIDTH(16)) bus16 ();

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; operands are scrambled during RUN to show they
    // are latched at the start edge.
    task automatic run8(input string tag, input logic sb, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        int cyc;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.sub   = sb;
        bus8.a     = av;
        bus8.b     = bv;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.sub   = ~sb;
        bus8.a     = ~av;
        bus8.b     = 8'h5A;
        check_eq({tag, "_busy"}, 32'(bus8.busy), 32'd1);
        cyc = 1;
        while (!bus8.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"},  32'(cyc), 32'd9);
        check_eq({tag, "_s"},    32'(bus8.s), 32'(es));
        check_eq({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
        check_eq({tag, "_ovf"},  32'(bus8.ovf), 32'(eo));
        check_eq({tag, "_zero"}, 32'(bus8.zero), 32'(ez));
        check_eq({tag, "_bsyd"}, 32'(bus8.busy), 32'd0);
    endtask

    task automatic run16(input string tag, input logic sb, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int cyc;
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.sub   = sb;
        bus16.a     = av;
        bus16.b     = bv;
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.a     = 16'h0000;
        bus16.b     = 16'h0000;
        cyc = 1;
        while (!bus16.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"},  32'(cyc), 32'd5);
        check_eq({tag, "_s"},    32'(bus16.s), 32'(es));
        check_eq({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
        check_eq({tag, "_ovf"},  32'(bus16.ovf), 32'(eo));
        check_eq({tag, "_zero"}, 32'(bus16.zero), 32'(ez));
    endtask

    initial begin
        int ndone;
        int done_cyc;
        logic [7:0] s_first;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus8.start  = 1'b0;
        bus8.sub    = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        bus16.start = 1'b0;
        bus16.sub   = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(bus8.busy), 32'd0);
        check_eq("rst_done", 32'(bus8.done), 32'd0);
        check_eq("rst_s",    32'(bus8.s), 32'd0);
        check_eq("rst_flags", 32'({bus8.cout, bus8.ovf, bus8.zero}), 32'd0);
        rst = 1'b0;

        // Directed arithmetic vectors (8-bit, bit-serial)
        run8("add3p5",   1'b0, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0, 1'b0);
        run8("sub8m1",   1'b1, 8'h08, 8'h01, 8'h07, 1'b1, 1'b0, 1'b0);
        run8("sub5m5",   1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run8("sub2m8",   1'b1, 8'h02, 8'h08, 8'hFA, 1'b0, 1'b0, 1'b0);
        run8("add7Fp1",  1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run8("sub80m1",  1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run8("addFFpFF", 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);

        // start pulses during RUN are ignored
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.sub   = 1'b0;
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        ndone    = 0;
        done_cyc = 0;
        s_first  = 8'h00;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (bus8.done) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = cyc;
                    s_first  = bus8.s;
                end
            end
            if (cyc == 3 || cyc == 5) begin
                bus8.start = 1'b1;
                bus8.sub   = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'h0F;
            end else begin
                bus8.start = 1'b0;
            end
        end
        check_eq("ign_ndone", 32'(ndone), 32'd1);
        check_eq("ign_lat",   32'(done_cyc), 32'd9);
        check_eq("ign_s",     32'(s_first), 32'h46);

        // start held high: back-to-back operations
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.sub   = 1'b0;
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        for (int cyc = 1; cyc <= 27; cyc++) begin
            @(negedge clk);
            check_eq("b2b_bd", 32'({bus8.busy, bus8.done}),
                     (cyc % 9 == 0) ? 32'd1 : 32'd2);
            if (cyc == 9) begin
                check_eq("b2b_s1", 32'(bus8.s), 32'h30);
                bus8.sub = 1'b1;
                bus8.a   = 8'h40;
                bus8.b   = 8'h01;
            end
            if (cyc == 18) begin
                check_eq("b2b_s2",  32'(bus8.s), 32'h3F);
                check_eq("b2b_c2",  32'(bus8.cout), 32'd1);
            end
            if (cyc == 27) begin
                check_eq("b2b_s3", 32'(bus8.s), 32'h3F);
                bus8.start = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("b2b_idle", 32'({bus8.busy, bus8.done}), 32'd0);

        // Reset mid-RUN discards the operation
        bus8.start = 1'b1;
        bus8.sub   = 1'b0;
        bus8.a     = 8'h11;
        bus8.b     = 8'h22;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_bd",    32'({bus8.busy, bus8.done}), 32'd0);
        check_eq("mrst_s",     32'(bus8.s), 32'd0);
        check_eq("mrst_flags", 32'({bus8.cout, bus8.ovf, bus8.zero}), 32'd0);
        ndone = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) ndone++;
        end
        check_eq("mrst_quiet", 32'(ndone), 32'd0);

        // 16-bit, 4-bit digits
        run16("w16_ffffp1", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run16("w16_sub",    1'b1, 16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run16("w16_ovf",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
